// File: rtl/exp7_unidade_controle_pkg.sv
// State codes shared by the Experiencia 7 control unit and anything that
// decodes db_estado.
package exp7_unidade_controle_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] INICIAL        = 5'd0;
  localparam logic [STATE_W-1:0] PREPARACAO     = 5'd1;
  localparam logic [STATE_W-1:0] REGISTRA_NIVEL = 5'd2;
  localparam logic [STATE_W-1:0] INICIO_RODADA  = 5'd3;
  localparam logic [STATE_W-1:0] MOSTRA         = 5'd4;
  localparam logic [STATE_W-1:0] PROXIMO_MOSTRA = 5'd5;
  localparam logic [STATE_W-1:0] INICIA_JOGADA  = 5'd6;
  localparam logic [STATE_W-1:0] ESPERA         = 5'd7;
  localparam logic [STATE_W-1:0] REGISTRA       = 5'd8;
  localparam logic [STATE_W-1:0] FEEDBACK       = 5'd9;
  localparam logic [STATE_W-1:0] COMPARA        = 5'd10;
  localparam logic [STATE_W-1:0] PROXIMA_JOGADA = 5'd11;
  localparam logic [STATE_W-1:0] PROXIMA_RODADA = 5'd12;
  localparam logic [STATE_W-1:0] PROXIMA_NOVA   = 5'd13;
  localparam logic [STATE_W-1:0] ESPERA_NOVA    = 5'd14;
  localparam logic [STATE_W-1:0] GRAVA_NOVA     = 5'd15;
  localparam logic [STATE_W-1:0] FIM_GANHOU     = 5'd16;
  localparam logic [STATE_W-1:0] FIM_PERDEU     = 5'd17;
  localparam logic [STATE_W-1:0] FIM_TIMEOUT    = 5'd18;

endpackage

// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the memory game: sequences setup, sequence display,
// player repetition with feedback and the optional mode-2 round extension.
module exp7_unidade_controle
  import exp7_unidade_controle_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         jogada_feita,
  input  logic         jogada_correta,
  input  logic         enderecoIgualRodada,
  input  logic         nivel_jogadas_reg,
  input  logic         nivel_tempo_reg,
  input  logic         modo2_reg,
  input  logic         meioCR,
  input  logic         fimCR,
  input  logic         meioTempo,
  input  logic         fimTempo,
  input  logic         meioTM,
  input  logic         fimTM,
  output logic         zeraR,
  output logic         registraN,
  output logic         registraR,
  output logic         gravaM,
  output logic         zeraC,
  output logic         contaC,
  output logic         zeraCR,
  output logic         contaCR,
  output logic         zeraTM,
  output logic         contaTM,
  output logic         zeraTempo,
  output logic         contaTempo,
  output logic         ativa_leds_mem,
  output logic         ativa_leds_jog,
  output logic         toca,
  output logic         pronto,
  output logic         ganhou,
  output logic         perdeu,
  output logic         timeout,
  output logic [4:0]   db_estado
);

  logic [STATE_W-1:0] estado;
  logic [STATE_W-1:0] proximo_estado;
  logic               ultima;
  logic               tout;

  // Game length and play timeout are selected by the registered options.
  assign ultima = nivel_jogadas_reg ? fimCR : meioCR;
  assign tout   = nivel_tempo_reg ? meioTempo : fimTempo;

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo_estado;
  end

  always_comb begin
    proximo_estado = INICIAL;
    case (estado)
      INICIAL:        proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo_estado = REGISTRA_NIVEL;
      REGISTRA_NIVEL: proximo_estado = INICIO_RODADA;
      INICIO_RODADA:  proximo_estado = MOSTRA;
      MOSTRA: begin
        if (fimTM) proximo_estado = enderecoIgualRodada ? INICIA_JOGADA : PROXIMO_MOSTRA;
        else       proximo_estado = MOSTRA;
      end
      PROXIMO_MOSTRA: proximo_estado = MOSTRA;
      INICIA_JOGADA:  proximo_estado = ESPERA;
      // A play arriving together with the timeout still counts.
      ESPERA: begin
        if (jogada_feita) proximo_estado = REGISTRA;
        else if (tout)    proximo_estado = FIM_TIMEOUT;
        else              proximo_estado = ESPERA;
      end
      REGISTRA:       proximo_estado = FEEDBACK;
      FEEDBACK:       proximo_estado = meioTM ? COMPARA : FEEDBACK;
      COMPARA: begin
        if (!jogada_correta)                     proximo_estado = FIM_PERDEU;
        else if (enderecoIgualRodada && ultima)    proximo_estado = FIM_GANHOU;
        else if (enderecoIgualRodada && modo2_reg) proximo_estado = PROXIMA_NOVA;
        else if (enderecoIgualRodada)              proximo_estado = PROXIMA_RODADA;
        else                                       proximo_estado = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo_estado = ESPERA;
      PROXIMA_RODADA: proximo_estado = INICIO_RODADA;
      PROXIMA_NOVA:   proximo_estado = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (jogada_feita) proximo_estado = GRAVA_NOVA;
        else if (tout)    proximo_estado = FIM_TIMEOUT;
        else              proximo_estado = ESPERA_NOVA;
      end
      GRAVA_NOVA:     proximo_estado = PROXIMA_RODADA;
      FIM_GANHOU:     proximo_estado = iniciar ? PREPARACAO : FIM_GANHOU;
      FIM_PERDEU:     proximo_estado = iniciar ? PREPARACAO : FIM_PERDEU;
      FIM_TIMEOUT:    proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:        proximo_estado = INICIAL;
    endcase
  end

  always_comb begin
    zeraR          = 1'b0;
    registraN      = 1'b0;
    registraR      = 1'b0;
    gravaM         = 1'b0;
    zeraC          = 1'b0;
    contaC         = 1'b0;
    zeraCR         = 1'b0;
    contaCR        = 1'b0;
    zeraTM         = 1'b0;
    contaTM        = 1'b0;
    zeraTempo      = 1'b0;
    contaTempo     = 1'b0;
    ativa_leds_mem = 1'b0;
    ativa_leds_jog = 1'b0;
    toca           = 1'b0;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    timeout        = 1'b0;
    case (estado)
      PREPARACAO: begin
        zeraR     = 1'b1;
        zeraC     = 1'b1;
        zeraCR    = 1'b1;
        zeraTM    = 1'b1;
        zeraTempo = 1'b1;
      end
      REGISTRA_NIVEL: registraN = 1'b1;
      INICIO_RODADA: begin
        zeraC  = 1'b1;
        zeraTM = 1'b1;
      end
      MOSTRA: begin
        ativa_leds_mem = 1'b1;
        toca           = 1'b1;
        contaTM        = 1'b1;
      end
      PROXIMO_MOSTRA: begin
        contaC = 1'b1;
        zeraTM = 1'b1;
      end
      INICIA_JOGADA: begin
        zeraC     = 1'b1;
        zeraTempo = 1'b1;
      end
      ESPERA:         contaTempo = 1'b1;
      REGISTRA: begin
        registraR = 1'b1;
        zeraTM    = 1'b1;
      end
      FEEDBACK: begin
        ativa_leds_jog = 1'b1;
        toca           = 1'b1;
        contaTM        = 1'b1;
      end
      PROXIMA_JOGADA, PROXIMA_NOVA: begin
        contaC    = 1'b1;
        zeraTempo = 1'b1;
      end
      PROXIMA_RODADA: contaCR = 1'b1;
      ESPERA_NOVA:    contaTempo = 1'b1;
      GRAVA_NOVA: begin
        gravaM    = 1'b1;
        registraR = 1'b1;
      end
      FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for the memory-game control unit: a table model of the game rules is
// checked every cycle, plus directed scenarios with literal expectations.
module tb_exp7_unidade_controle;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, jogada_correta;
  logic m_eir, m_meiocr;
  logic nivel_jogadas_reg, nivel_tempo_reg, modo2_reg, fimCR;
  logic meioTempo, fimTempo, meioTM, fimTM;
  logic enderecoIgualRodada, meioCR;
  logic zeraR, registraN, registraR, gravaM, zeraC, contaC, zeraCR, contaCR;
  logic zeraTM, contaTM, zeraTempo, contaTempo;
  logic ativa_leds_mem, ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;
  logic [18:0] dut_outs;

  int n_cmp = 0;
  int n_fail = 0;

  // Small datapath stand-in: address and round counters driven by the DUT.
  bit auto_dp = 0;
  int addr = 0;
  int rnd = 0;

  always #5 clock = ~clock;

  assign enderecoIgualRodada = auto_dp ? (addr == rnd) : m_eir;
  assign meioCR              = auto_dp ? (rnd == 7)    : m_meiocr;

  always @(posedge clock) begin
    if (zeraC) addr <= 0;
    else if (contaC) addr <= addr + 1;
    if (zeraCR) rnd <= 0;
    else if (contaCR) rnd <= rnd + 1;
  end

  exp7_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada),
    .nivel_jogadas_reg(nivel_jogadas_reg), .nivel_tempo_reg(nivel_tempo_reg),
    .modo2_reg(modo2_reg), .meioCR(meioCR), .fimCR(fimCR),
    .meioTempo(meioTempo), .fimTempo(fimTempo), .meioTM(meioTM), .fimTM(fimTM),
    .zeraR(zeraR), .registraN(registraN), .registraR(registraR), .gravaM(gravaM),
    .zeraC(zeraC), .contaC(contaC), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraTM(zeraTM), .contaTM(contaTM), .zeraTempo(zeraTempo), .contaTempo(contaTempo),
    .ativa_leds_mem(ativa_leds_mem), .ativa_leds_jog(ativa_leds_jog), .toca(toca),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado)
  );

  assign dut_outs = {zeraR, registraN, registraR, gravaM, zeraC, contaC, zeraCR,
                     contaCR, zeraTM, contaTM, zeraTempo, contaTempo, ativa_leds_mem,
                     ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout};

  localparam int B_ZR = 18, B_RN = 17, B_RR = 16, B_GM = 15, B_ZC = 14, B_CC = 13;
  localparam int B_ZCR = 12, B_CCR = 11, B_ZTM = 10, B_CTM = 9, B_ZT = 8, B_CT = 7;
  localparam int B_LM = 6, B_LJ = 5, B_TOCA = 4, B_PR = 3, B_GA = 2, B_PE = 1, B_TO = 0;

  // Output table of the game: which controls each step of the game raises.
  function automatic logic [18:0] model_outs(int s);
    logic [18:0] o = '0;
    case (s)
      1:  begin o[B_ZR] = 1; o[B_ZC] = 1; o[B_ZCR] = 1; o[B_ZTM] = 1; o[B_ZT] = 1; end
      2:  o[B_RN] = 1;
      3:  begin o[B_ZC] = 1; o[B_ZTM] = 1; end
      4:  begin o[B_LM] = 1; o[B_TOCA] = 1; o[B_CTM] = 1; end
      5:  begin o[B_CC] = 1; o[B_ZTM] = 1; end
      6:  begin o[B_ZC] = 1; o[B_ZT] = 1; end
      7, 14: o[B_CT] = 1;
      8:  begin o[B_RR] = 1; o[B_ZTM] = 1; end
      9:  begin o[B_LJ] = 1; o[B_TOCA] = 1; o[B_CTM] = 1; end
      11, 13: begin o[B_CC] = 1; o[B_ZT] = 1; end
      12: o[B_CCR] = 1;
      15: begin o[B_GM] = 1; o[B_RR] = 1; end
      16: begin o[B_PR] = 1; o[B_GA] = 1; end
      17: begin o[B_PR] = 1; o[B_PE] = 1; end
      18: begin o[B_PR] = 1; o[B_TO] = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Game rules: where play goes next from each step.
  function automatic int model_next(int s);
    bit last_round = nivel_jogadas_reg ? fimCR : meioCR;
    bit timed_out  = nivel_tempo_reg ? meioTempo : fimTempo;
    bit at_end     = enderecoIgualRodada;
    case (s)
      0:  return iniciar ? 1 : 0;
      1, 2: return s + 1;
      3, 5: return 4;
      4:  return !fimTM ? 4 : (at_end ? 6 : 5);
      6, 11: return 7;
      7:  return jogada_feita ? 8 : (timed_out ? 18 : 7);
      8:  return 9;
      9:  return meioTM ? 10 : 9;
      10: begin
        if (!jogada_correta) return 17;
        if (at_end && last_round) return 16;
        if (at_end) return modo2_reg ? 13 : 12;
        return 11;
      end
      12: return 3;
      13: return 14;
      14: return jogada_feita ? 15 : (timed_out ? 18 : 14);
      15: return 12;
      16, 17, 18: return iniciar ? 1 : s;
      default: return 0;
    endcase
  endfunction

  int  m_state = 0;
  bit  model_valid = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_state <= 0;
      model_valid <= 1;
    end else begin
      m_state <= model_next(m_state);
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      n_cmp++;
      if (db_estado !== 5'(m_state) || dut_outs !== model_outs(m_state)) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t: got state=%0d outs=%b, required state=%0d outs=%b",
                 $time, db_estado, dut_outs, m_state, model_outs(m_state));
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input string nm);
    int n = 0;
    while (db_estado != 5'(s) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check(nm, int'(db_estado), s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    wait_state(1, "start_prep");
    iniciar = 1'b0;
  endtask

  task automatic clear_inputs();
    iniciar = 0; jogada_feita = 0; jogada_correta = 0; m_eir = 0; m_meiocr = 0;
    nivel_jogadas_reg = 0; nivel_tempo_reg = 0; modo2_reg = 0; fimCR = 0;
    meioTempo = 0; fimTempo = 0; meioTM = 0; fimTM = 0; auto_dp = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_state", int'(db_estado), 0);
    check("reset_outs", int'(dut_outs), 0);

    // Reset in the middle of the display phase.
    start_game();
    @(negedge clock); check("t1_state2", int'(db_estado), 2); check("t1_regN_2", int'(registraN), 1);
    @(negedge clock); check("t1_state3", int'(db_estado), 3);
    wait_state(4, "t1_mostra");
    @(negedge clock); check("t1_hold_mostra", int'(db_estado), 4);
    do_reset();
    check("t1_mid_reset_state", int'(db_estado), 0);
    check("t1_mid_reset_outs", int'(dut_outs), 0);
    iniciar = 1'b1;
    @(negedge clock); check("t1_seq1", int'(db_estado), 1); check("t1_regN_1", int'(registraN), 0);
    iniciar = 1'b0;
    @(negedge clock); check("t1_seq2", int'(db_estado), 2); check("t1_regN_2b", int'(registraN), 1);
    @(negedge clock); check("t1_seq3", int'(db_estado), 3); check("t1_regN_3", int'(registraN), 0);

    // Full mode-1 game, 8 rounds, every play correct.
    do_reset();
    auto_dp = 1; jogada_feita = 1; jogada_correta = 1; fimTM = 1; meioTM = 1;
    start_game();
    wait_state(16, "t2_win");
    check("t2_ganhou", int'(ganhou), 1);
    check("t2_pronto", int'(pronto), 1);
    check("t2_rounds", rnd, 7);
    auto_dp = 0;

    // Wrong second play of round 2.
    do_reset();
    clear_inputs();
    start_game();
    fimTM = 1; meioTM = 1; jogada_feita = 1; jogada_correta = 1; m_eir = 1;
    wait_state(12, "t3_round1_done");
    m_eir = 0;
    wait_state(5, "t3_show_next");
    m_eir = 1;
    wait_state(6, "t3_play_start");
    m_eir = 0;
    wait_state(11, "t3_next_play");
    jogada_correta = 0;
    wait_state(17, "t3_lost");
    check("t3_perdeu", int'(perdeu), 1);
    check("t3_pronto", int'(pronto), 1);
    iniciar = 1;
    @(negedge clock); check("t3_restart", int'(db_estado), 1);
    iniciar = 0;

    // Timeouts with both time levels.
    do_reset();
    clear_inputs();
    nivel_tempo_reg = 1; fimTM = 1; m_eir = 1;
    start_game();
    wait_state(7, "t4_espera");
    repeat (3) @(negedge clock);
    check("t4_wait_hold", int'(db_estado), 7);
    meioTempo = 1;
    @(negedge clock); check("t4_timeout_short", int'(db_estado), 18);
    check("t4_timeout_flag", int'(timeout), 1);
    nivel_tempo_reg = 0;
    start_game();
    wait_state(7, "t4_espera_long");
    repeat (3) @(negedge clock);
    check("t4_long_hold", int'(db_estado), 7);
    fimTempo = 1;
    @(negedge clock); check("t4_timeout_long", int'(db_estado), 18);

    // Play arriving together with the timeout.
    fimTempo = 0; meioTempo = 0; nivel_tempo_reg = 1;
    start_game();
    wait_state(7, "t5_espera");
    @(negedge clock);
    jogada_feita = 1; meioTempo = 1;
    @(negedge clock); check("t5_play_wins", int'(db_estado), 8);

    // Mode 2: first round extended with a new recorded play.
    do_reset();
    clear_inputs();
    modo2_reg = 1; jogada_feita = 1; jogada_correta = 1; m_eir = 1; fimTM = 1; meioTM = 1;
    start_game();
    wait_state(13, "t6_nova");
    @(negedge clock); check("t6_espera_nova", int'(db_estado), 14);
    @(negedge clock); check("t6_grava", int'(db_estado), 15); check("t6_gravaM_on", int'(gravaM), 1);
    @(negedge clock); check("t6_prox_rodada", int'(db_estado), 12);
    check("t6_gravaM_off", int'(gravaM), 0); check("t6_contaCR", int'(contaCR), 1);
    @(negedge clock); check("t6_inicio_rodada", int'(db_estado), 3);

    // Mode 2 on the final round wins directly; long game ignores meioCR.
    do_reset();
    m_meiocr = 1;
    start_game();
    wait_state(16, "t6_final_win");
    do_reset();
    modo2_reg = 0; nivel_jogadas_reg = 1;
    start_game();
    wait_state(12, "t6_long_game_continues");

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
